// File: rtl/ram_pkg.sv
// Shared constants and controller state encoding for the async single-port RAM
// and everything that talks to it.
package ram_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD,
    ST_READ,
    ST_DONE
  } ram_ctrl_state_t;

endpackage

// File: rtl/ram_ctrl.sv
// Valid/ready request front end for the asynchronous single-port RAM: sequences
// address setup, re/we strobes, write data hold and tristate bus turnaround.
module ram_ctrl #(
  parameter int unsigned ADDR_W   = ram_pkg::ADDR_W,
  parameter int unsigned DATA_W   = ram_pkg::DATA_W,
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  import ram_pkg::*;

  localparam int unsigned CNT_MAX = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  ram_ctrl_state_t   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              drive_q, drive_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = wr_q ? ST_WRITE : ST_READ;
      end
      ST_WRITE: begin
        if (cnt_q == CNT_W'(WR_PULSE - 1)) state_d = ST_HOLD;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      ST_READ: begin
        if (cnt_q == CNT_W'(RD_WAIT)) begin
          rdata_d = ram_data;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD, ST_DONE: state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase

    // Strobes and bus enable are decoded from the next state so they come out
    // of flops yet line up exactly with the state they belong to.
    re_d        = (state_d == ST_READ);
    we_d        = (state_d == ST_WRITE);
    rsp_valid_d = (state_d == ST_HOLD) || (state_d == ST_DONE);
    drive_d     = wr_d && ((state_d == ST_SETUP) || (state_d == ST_WRITE) ||
                           (state_d == ST_HOLD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      drive_q     <= drive_d;
      re_q        <= re_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign ram_re    = re_q;
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_data  = drive_q ? wdata_q : 'z;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: default-parameter instance plus a slow-timing
// instance, each attached to a behavioural asynchronous RAM.
module tb_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, rsp_valid, ram_re, ram_we;
  logic [31:0] rsp_rdata;
  logic [8:0]  ram_addr;
  wire  [31:0] ram_data;

  logic        b_req_valid, b_req_we;
  logic [8:0]  b_req_addr;
  logic [31:0] b_req_wdata;
  logic        b_req_ready, b_rsp_valid, b_ram_re, b_ram_we;
  logic [31:0] b_rsp_rdata;
  logic [8:0]  b_ram_addr;
  wire  [31:0] b_ram_data;

  logic [31:0] mem_a [512];
  logic [31:0] mem_b [512];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ram_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  ram_ctrl #(.RD_WAIT(3), .WR_PULSE(2)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .ram_re(b_ram_re), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_data(b_ram_data)
  );

  // Behavioural RAMs: combinational read while re is high, write captured while we is high.
  assign ram_data   = ram_re   ? mem_a[ram_addr]   : 'z;
  assign b_ram_data = b_ram_re ? mem_b[b_ram_addr] : 'z;
  always @(posedge clk) if (ram_we)   mem_a[ram_addr]   <= ram_data;
  always @(posedge clk) if (b_ram_we) mem_b[b_ram_addr] <= b_ram_data;

  function automatic logic bus_released(input logic [31:0] v);
    return (v === 32'bz) || (v === 32'h0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req_a(input logic we, input logic [8:0] addr, input logic [31:0] data,
                          output int lat, output logic [31:0] rdata);
    int n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin step(); lat++; end
    if (!rsp_valid) lat = -1;
    rdata = rsp_rdata;
  endtask

  task automatic do_req_b(input logic we, input logic [8:0] addr, input logic [31:0] data,
                          output int lat, output int re_cyc, output int we_cyc,
                          output logic [31:0] rdata);
    int n = 0;
    re_cyc = 0; we_cyc = 0;
    while (!b_req_ready && n < 20) begin step(); n++; end
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = data;
    step();
    b_req_valid = 1'b0;
    lat = 1;
    forever begin
      if (b_ram_re) re_cyc++;
      if (b_ram_we) we_cyc++;
      if (b_rsp_valid || lat >= 30) break;
      step();
      lat++;
    end
    if (!b_rsp_valid) lat = -1;
    rdata = b_rsp_rdata;
  endtask

  // Runs alongside the directed tests: strobe exclusivity, no bus drive during a
  // read, and address stability across consecutive strobe cycles.
  task automatic monitor();
    logic       prev_s = 1'b0;
    logic [8:0] prev_a = '0;
    logic       ok;
    forever begin
      @(negedge clk);
      if (!rst && (ram_re || ram_we)) begin
        ok = !(ram_re && ram_we) && !(ram_re && dut.drive_q) &&
             !(prev_s && (ram_addr !== prev_a));
        total_cnt++;
        if (!ok) $display("FAIL invariant t=%0t: re=%b we=%b drive=%b addr=%h prev=%h required exclusive strobes, no drive on read, stable addr",
                          $time, ram_re, ram_we, dut.drive_q, ram_addr, prev_a);
        else pass_cnt++;
      end
      prev_s = !rst && (ram_re || ram_we);
      prev_a = ram_addr;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    repeat (5) step();
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", req_ready); else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); else pass_cnt++;
    total_cnt++;
    if ({ram_re, ram_we} !== 2'b00) $display("FAIL reset_strobes: got %b required 00", {ram_re, ram_we}); else pass_cnt++;
    total_cnt++;
    if (!bus_released(ram_data)) $display("FAIL reset_bus: got %h required z", ram_data); else pass_cnt++;
    total_cnt++;
    if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h required 0", rsp_rdata); else pass_cnt++;
    total_cnt++;
    if (ram_addr !== 9'h0) $display("FAIL reset_addr: got %h required 0", ram_addr); else pass_cnt++;
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] rd;
    for (int i = 0; i < 5; i++) begin
      do_req_a(1'b1, 9'(i), 32'h1 << i, lat, rd);
      total_cnt++;
      if (lat !== 3) $display("FAIL wr_latency[%0d]: got %0d required 3", i, lat); else pass_cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      do_req_a(1'b0, 9'(i), 32'h0, lat, rd);
      total_cnt++;
      if (lat !== 4) $display("FAIL rd_latency[%0d]: got %0d required 4", i, lat); else pass_cnt++;
      total_cnt++;
      if (rd !== (32'h1 << i)) $display("FAIL rd_data[%0d]: got %h required %h", i, rd, 32'h1 << i); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] rd;
    do_req_a(1'b1, 9'd511, 32'hDEADBEEF, lat, rd);
    total_cnt++;
    if (lat !== 3) $display("FAIL top_wr_latency: got %0d required 3", lat); else pass_cnt++;
    do_req_a(1'b0, 9'd511, 32'h0, lat, rd);
    total_cnt++;
    if (lat !== 4) $display("FAIL top_rd_latency: got %0d required 4", lat); else pass_cnt++;
    total_cnt++;
    if (rd !== 32'hDEADBEEF) $display("FAIL top_rd_data: got %h required deadbeef", rd); else pass_cnt++;
  endtask

  task automatic test_held_request();
    logic [31:0] old31;
    int lat;
    old31 = mem_a[31];
    while (!req_ready) step();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'd30; req_wdata = 32'h00001234;
    step();                                   // SETUP of first write
    req_addr = 9'd31; req_wdata = 32'h5555AAAA;
    step();                                   // WRITE
    total_cnt++;
    if (req_ready !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 9'd30)
      $display("FAIL held_write_cycle: ready=%b we=%b addr=%h required 0 1 01e", req_ready, ram_we, ram_addr);
    else pass_cnt++;
    total_cnt++;
    if (mem_a[31] !== old31) $display("FAIL held_mem_write: got %h required %h", mem_a[31], old31); else pass_cnt++;
    step();                                   // HOLD
    total_cnt++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0) $display("FAIL held_hold: rsp=%b ready=%b required 1 0", rsp_valid, req_ready); else pass_cnt++;
    total_cnt++;
    if (mem_a[30] !== 32'h00001234) $display("FAIL held_first_data: got %h required 00001234", mem_a[30]); else pass_cnt++;
    step();                                   // IDLE, held request accepted on next edge
    total_cnt++;
    if (req_ready !== 1'b1 || mem_a[31] !== old31) $display("FAIL held_idle: ready=%b mem31=%h required 1 %h", req_ready, mem_a[31], old31); else pass_cnt++;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin step(); lat++; end
    total_cnt++;
    if (lat !== 3 || mem_a[31] !== 32'h5555AAAA) $display("FAIL held_second: lat=%0d mem31=%h required 3 5555aaaa", lat, mem_a[31]); else pass_cnt++;
  endtask

  task automatic test_slow_params();
    int lat, rc, wc;
    logic [31:0] rd;
    do_req_b(1'b1, 9'd3, 32'hCAFE0003, lat, rc, wc, rd);
    total_cnt++;
    if (lat !== 4) $display("FAIL slow_wr_latency: got %0d required 4", lat); else pass_cnt++;
    total_cnt++;
    if (wc !== 2 || rc !== 0) $display("FAIL slow_wr_strobes: we=%0d re=%0d required 2 0", wc, rc); else pass_cnt++;
    do_req_b(1'b0, 9'd3, 32'h0, lat, rc, wc, rd);
    total_cnt++;
    if (lat !== 6) $display("FAIL slow_rd_latency: got %0d required 6", lat); else pass_cnt++;
    total_cnt++;
    if (rc !== 4 || wc !== 0) $display("FAIL slow_rd_strobes: re=%0d we=%0d required 4 0", rc, wc); else pass_cnt++;
    total_cnt++;
    if (rd !== 32'hCAFE0003) $display("FAIL slow_rd_data: got %h required cafe0003", rd); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] rd;
    logic seen_rsp;
    do_req_a(1'b1, 9'd7, 32'h7, lat, rd);
    do_req_a(1'b0, 9'd7, 32'h0, lat, rd);
    total_cnt++;
    if (rd !== 32'h7) $display("FAIL mid_pre_read: got %h required 00000007", rd); else pass_cnt++;
    while (!req_ready) step();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'd7; req_wdata = 32'hAAAA5555;
    step();
    req_valid = 1'b0;
    step();                                   // WRITE with ram_we high
    total_cnt++;
    if (ram_we !== 1'b1) $display("FAIL mid_we_high: got %b required 1", ram_we); else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if ({ram_re, ram_we} !== 2'b00 || !bus_released(ram_data))
      $display("FAIL mid_after_rst: strobes=%b bus=%h required 00 z", {ram_re, ram_we}, ram_data);
    else pass_cnt++;
    total_cnt++;
    if (rsp_rdata !== 32'h0 || req_ready !== 1'b1) $display("FAIL mid_rdata_ready: rdata=%h ready=%b required 0 1", rsp_rdata, req_ready); else pass_cnt++;
    seen_rsp = rsp_valid;
    repeat (3) begin step(); seen_rsp |= rsp_valid; end
    total_cnt++;
    if (seen_rsp !== 1'b0) $display("FAIL mid_no_rsp: got %b required 0", seen_rsp); else pass_cnt++;
    do_req_a(1'b0, 9'd7, 32'h0, lat, rd);
    total_cnt++;
    if (rd !== 32'h7 && rd !== 32'hAAAA5555) $display("FAIL mid_read7: got %h required 00000007 or aaaa5555", rd); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_write_read();
    test_back_to_back();
    test_held_request();
    test_slow_params();
    test_reset_mid();
    repeat (3) step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
